fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the pd5 pipeline, directly upstream of the instruction memory and of decode. Owns the program counter, drives the read address into the instruction memory, captures the combinational read data together with its PC into a small instruction queue, and hands entries to decode with a valid/ready handshake. Accepts PC redirects from execute (branches/jumps), flushing any wrong-path entries.

## Interface
Parameters:
- RESET_PC, 32'h01000000, PC loaded on reset (base of instruction memory)
- QUEUE_DEPTH, 2, instruction queue entries; power of two, ≥2

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- imem_addr  output  32  byte address to instruction memory; equals current PC
- imem_rw  output  1  instruction-memory read_write; constant 0 (read)
- imem_rdata  input  32  instruction word for imem_addr, valid same cycle (combinational read)
- redirect_valid  input  1  execute requests PC change this cycle
- redirect_pc  input  32  redirect target
- dec_ready  input  1  decode accepts head entry this cycle
- dec_valid  output  1  head entry valid
- dec_pc  output  32  PC of head entry
- dec_insn  output  32  instruction of head entry
- queue_count  output  $clog2(QUEUE_DEPTH)+1  occupied entries
- misalign  output  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- State: pc, queue (pc+insn per entry), rd_ptr, wr_ptr, count, misalign, halted.
- dec_valid = (count != 0) && !redirect_valid; dec_pc/dec_insn = head entry (0 when empty).
- pop = dec_valid && dec_ready.
- push_en = !redirect_valid && !halted && (count < QUEUE_DEPTH || pop).
- push_en: write {pc, imem_rdata} at wr_ptr; pc <= pc + 4 (mod 2^32 wrap).
- !push_en and no redirect: pc held, imem_addr unchanged.
- Simultaneous push and pop: count unchanged, both pointers advance; allowed at full and at empty-plus-push (pop only if count≠0).
- Pointers wrap modulo QUEUE_DEPTH.
- redirect_valid: highest priority; next edge count <= 0, rd_ptr <= wr_ptr, pc <= target; no push or pop that cycle. Decode must treat its own head as killed.
- Reset: pc = RESET_PC, count = 0, pointers 0, misalign = 0, halted = 0; outputs: dec_valid 0, dec_pc 0, dec_insn 0, queue_count 0, imem_addr RESET_PC, imem_rw 0.
- Reset asserted mid-operation: queue cleared immediately (async), no partial entry retained.

## Timing
- First edge after reset release pushes RESET_PC; dec_valid = 1 in the following cycle.
- Redirect sampled at edge N: imem_addr = target during cycle after N; entry available (dec_valid) one edge later. Redirect penalty 2 cycles.
- dec_ready held 1: one instruction per cycle, queue_count steady at 1.
- dec_ready held 0: queue fills in QUEUE_DEPTH cycles, then pc frozen.
- Combinational paths: dec_ready → push_en; redirect_valid → dec_valid.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0] ≠ 0 sets misalign (sticky) and halted; queue flushed, no further pushes until reset; pc <= redirect_pc unchanged.
- Undefined: pc <= {redirect_pc[31:2], 2'b00}; misalign tied 0, halted never set.

## Structure
- Shared constants header: RESET_PC default, instruction width (32), NOP encoding 32'h00000013 for bench/decode use.
- One sub-module: fetch_queue (circular FIFO, push/pop/flush, count, head outputs); fetch_stage holds PC and control.

## Test plan
- Reset release, dec_ready=1 → dec_pc sequence 0x01000000, 0x01000004, 0x01000008 on consecutive cycles, dec_insn matches memory.
- dec_ready=0 for 5 cycles → queue_count reaches 2, imem_addr frozen at 0x01000008; release → 0x01000000 popped next cycle, no loss/duplication.
- Redirect to 0x01000040 with queue full → dec_valid 0 in redirect cycle and next, then dec_pc = 0x01000040.
- Redirect and dec_ready=1 in same cycle at full → no pop counted, queue_count 0 after edge.
- Redirect to 0x01000042: with macro misalign=1, dec_valid stays 0; without macro next dec_pc = 0x01000040.
- Reset asserted mid-stream with count=2 → immediately queue_count 0, imem_addr 0x01000000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants and helpers for the pd5 fetch stage.
// Optional misaligned-redirect trap is selected with FETCH_MISALIGN_TRAP_EN (see fetch_stage.sv).
package fetch_stage_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0100_0000;
  localparam int          INSN_W         = 32;
  localparam logic [31:0] NOP_INSN       = 32'h0000_0013;
  localparam int          ENTRY_W        = 32 + INSN_W;

  // Queue entry layout: {pc, insn}
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [31:0] pc,
                                                    input logic [INSN_W-1:0] insn);
    return {pc, insn};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue of {pc, insn} entries with push, pop and flush.
// Head outputs read as zero whenever the queue is empty.
module fetch_queue
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        flush,
  input  logic [ENTRY_W-1:0]          wr_data,
  output logic [ENTRY_W-1:0]          head_data,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_stage.sv
// pd5 instruction-fetch stage: owns the PC, reads imem combinationally, queues {pc,insn} for decode.
// Define FETCH_MISALIGN_TRAP_EN to trap (sticky misalign + halt) on redirects with target[1:0] != 0.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = FETCH_RESET_PC,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  output logic [31:0]                   imem_addr,
  output logic                          imem_rw,
  input  logic [31:0]                   imem_rdata,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  input  logic                          dec_ready,
  output logic                          dec_valid,
  output logic [31:0]                   dec_pc,
  output logic [31:0]                   dec_insn,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count,
  output logic                          misalign
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  // Handshake: an entry transfers to decode on a cycle where dec_valid && dec_ready;
  // a redirect in the same cycle masks dec_valid, so nothing transfers then.
  logic               pc_valid_unused;
  logic [31:0]        pc;
  logic               halted;
  logic               pop;
  logic               push_en;
  logic [CW-1:0]      count;
  logic [ENTRY_W-1:0] head;

  assign pc_valid_unused = ^redirect_pc[1:0];

  assign dec_valid = (count != '0) && !redirect_valid;
  assign pop       = dec_valid && dec_ready;
  assign push_en   = !redirect_valid && !halted && ((count < CW'(QUEUE_DEPTH)) || pop);

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      misalign <= 1'b0;
      halted   <= 1'b0;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign <= 1'b1;
        halted   <= 1'b1;
      end
    end else if (push_en) begin
      pc <= pc + 32'd4;
    end
  end
`else
  assign misalign = 1'b0;
  assign halted   = 1'b0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[31:2], 2'b00};
    end else if (push_en) begin
      pc <= pc + 32'd4;
    end
  end
`endif

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push_en),
    .pop       (pop),
    .flush     (redirect_valid),
    .wr_data   (pack_entry(pc, imem_rdata)),
    .head_data (head),
    .count     (count)
  );

  assign imem_addr   = pc;
  assign imem_rw     = 1'b0;
  assign dec_pc      = head[ENTRY_W-1:INSN_W];
  assign dec_insn    = head[INSN_W-1:0];
  assign queue_count = count;

endmodule
